// File: rtl/bram_seq_reader_pkg.sv
// Shared types and constants for the sequential BRAM reader.
package bram_seq_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned CNT_W      = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/bram_seq_reader_skid_fifo2.sv
// Two-entry synchronous FIFO with a registered head; used as the skid buffer
// between the BRAM read port and the output stream.
module skid_fifo2
    import bram_seq_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             head_valid_o,
    output logic [WIDTH-1:0] head_data_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic             pop_eff;

    assign pop_eff = pop_i & valid_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push_i, pop_eff})
            2'b10: begin
                if (count_q == CNT_W'(0)) head_d = push_data_i;
                else                      tail_d = push_data_i;
                count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - CNT_W'(1);
            end
            2'b11: begin
                // Simultaneous push/pop keeps the count; the new word lands
                // wherever the popped head leaves the first free slot.
                if (count_q == CNT_W'(1)) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
        valid_d = (count_d != CNT_W'(0));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign count_o      = count_q;
    assign head_valid_o = valid_q;
    assign head_data_o  = head_q;

endmodule

// File: rtl/bram_seq_reader.sv
// Walks consecutive BRAM addresses for a job and streams the words out through
// a two-entry skid buffer that covers the one-cycle read latency.
module bram_seq_reader
    import bram_seq_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   num_words,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_write_en,
    input  logic [DATA_WIDTH-1:0] bram_data_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] counter_q, counter_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;

    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_head;
    logic                  pop;
    logic                  issue;
    logic                  last_issue;
    logic [2:0]            occ;

    assign pop = fifo_valid & out_ready;

    // Occupancy one cycle ahead: buffered + in flight, less what leaves now.
    assign occ        = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
    assign issue      = (state_q == ST_READ) && (remaining_q != '0) && (occ < 3'(SKID_DEPTH));
    assign last_issue = (remaining_q == (ADDR_WIDTH + 1)'(1));

    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        remaining_d     = remaining_q;
        inflight_d      = issue;
        inflight_last_d = issue & last_issue;
        done_d          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (num_words != '0) begin
                        state_d     = ST_READ;
                        counter_d   = start_addr;
                        remaining_d = num_words;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    counter_d   = counter_q + 1'b1;
                    remaining_d = remaining_q - 1'b1;
                    if (last_issue) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (occ == 3'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            counter_q       <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
        end
    end

    skid_fifo2 #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .clk_i        (clk),
        .rst_i        (rst),
        .push_i       (inflight_q),
        .push_data_i  ({inflight_last_q, bram_data_out}),
        .pop_i        (pop),
        .count_o      (fifo_count),
        .head_valid_o (fifo_valid),
        .head_data_o  (fifo_head)
    );

    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign bram_addr     = counter_q;
    assign bram_write_en = 1'b0;
    assign out_valid     = fifo_valid;
    assign out_data      = fifo_head[DATA_WIDTH-1:0];
    assign out_last      = fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_bram_seq_reader.sv
// Randomised bench for bram_seq_reader: a BRAM model feeds the DUT and every
// job is scored against a queue of words derived from start address and count.
module tb_bram_seq_reader;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   num_words;
    logic          busy;
    logic          done;
    logic [AW-1:0] bram_addr;
    logic          bram_write_en;
    logic [DW-1:0] bram_data_out = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    logic [DW-1:0] mem [DEPTH];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) bram_data_out <= mem[bram_addr];

    bram_seq_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .start_addr    (start_addr),
        .num_words     (num_words),
        .busy          (busy),
        .done          (done),
        .bram_addr     (bram_addr),
        .bram_write_en (bram_write_en),
        .bram_data_out (bram_data_out),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic idle_checks(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_eq("idle_done",  32'(done),      32'd0);
            check_eq("idle_valid", 32'(out_valid), 32'd0);
            check_eq("idle_busy",  32'(busy),      32'd0);
        end
    endtask

    // One complete job: expected stream is mem[(sa+i) mod DEPTH], last on i=n-1.
    task automatic run_job(input logic [AW-1:0] sa, input int unsigned n,
                           input bit rnd_ready, input bit spurious);
        logic [DW:0]  exp_q[$];
        logic [DW:0]  word;
        logic [DW:0]  held = '0;
        bit           hold = 1'b0;
        bit           rdy;
        int           cyc = 0;
        int           first_valid = -1;
        int           done_cyc = -1;
        int           last_pop = -1;
        int unsigned  popped = 0;

        for (int unsigned i = 0; i < n; i++)
            exp_q.push_back({i == n - 1, mem[(32'(sa) + i) % DEPTH]});

        start      = 1'b1;
        start_addr = sa;
        num_words  = (AW + 1)'(n);
        out_ready  = 1'b1;

        while (done_cyc < 0 && cyc < 200) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            if (done) done_cyc = cyc;
            if (hold) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_word", 32'({out_last, out_data}), 32'(held));
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (done_cyc < 0) check_eq("busy", 32'(busy), 32'(n > 0));
            check_eq("write_en", 32'(bram_write_en), 32'd0);
            if (busy)
                check_eq("ahead", 32'(((32'(bram_addr) - 32'(sa) - popped) % DEPTH) <= 2), 32'd1);
            if (exp_q.size() == 0) check_eq("spurious_valid", 32'(out_valid), 32'd0);

            rdy       = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready = rdy;
            if (out_valid && rdy && exp_q.size() > 0) begin
                word = exp_q.pop_front();
                check_eq("word", 32'({out_last, out_data}), 32'(word));
                popped++;
                last_pop = cyc;
            end
            hold = out_valid && !rdy;
            held = {out_last, out_data};

            if (spurious && busy && $urandom_range(0, 7) == 0) begin
                start      = 1'b1;
                start_addr = AW'($urandom);
                num_words  = (AW + 1)'($urandom_range(0, DEPTH));
            end
        end
        start = 1'b0;

        check_eq("done_seen", 32'(done_cyc > 0), 32'd1);
        check_eq("all_words", 32'(exp_q.size()), 32'd0);
        check_eq("busy_at_done", 32'(busy), 32'd0);
        if (n > 0) begin
            check_eq("first_valid", 32'(first_valid), 32'd3);
            check_eq("done_after_last_pop", 32'(done_cyc), 32'(last_pop + 1));
            if (!rnd_ready) check_eq("throughput", 32'(done_cyc), 32'(n + 3));
        end else begin
            check_eq("zero_done", 32'(done_cyc), 32'd1);
            check_eq("zero_no_valid", 32'(first_valid), 32'hffff_ffff);
        end
        out_ready = 1'b1;
        idle_checks(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        num_words  = '0;
        out_ready  = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = DW'(i + 8'h10);

        repeat (2) @(negedge clk);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_done",  32'(done),      32'd0);
        check_eq("rst_addr",  32'(bram_addr), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_last",  32'(out_last),  32'd0);
        check_eq("rst_data",  32'(out_data),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_job(4'd2,  5,  1'b0, 1'b0);
        run_job(4'd14, 4,  1'b0, 1'b0);
        run_job(4'd0,  6,  1'b1, 1'b0);
        run_job(4'd9,  0,  1'b0, 1'b0);
        run_job(4'd5,  16, 1'b0, 1'b0);
        run_job(4'd5,  16, 1'b1, 1'b1);

        // Abandon a job three cycles in, with a coincident start that must lose.
        start      = 1'b1;
        start_addr = 4'd3;
        num_words  = 5'd6;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
        rst        = 1'b1;
        start      = 1'b1;
        start_addr = 4'd8;
        num_words  = 5'd4;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check_eq("post_rst_valid", 32'(out_valid), 32'd0);
        check_eq("post_rst_busy",  32'(busy),      32'd0);
        idle_checks(4);
        run_job(4'd7, 5, 1'b1, 1'b0);

        for (int j = 0; j < 25; j++) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            run_job(AW'($urandom), $urandom_range(0, DEPTH), $urandom_range(0, 1) == 1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_seq_reader.md
Name: bram_seq_reader

Overview:
- Downstream consumer of the single-port BRAM (1-cycle registered read latency, no read enable).
- Given a start address and word count, it walks consecutive BRAM addresses and emits each word on a valid/ready stream toward the alignment datapath.
- A 2-entry skid buffer hides the read latency and absorbs backpressure; the block sustains 1 word/cycle when the consumer is always ready.

Parameters:
ADDR_WIDTH, 4, BRAM address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, BRAM and stream data width

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
start_addr  input  ADDR_WIDTH  first BRAM address to read
num_words  input  ADDR_WIDTH+1  words to read, 0..2**ADDR_WIDTH
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when a job completes
bram_addr  output  ADDR_WIDTH  drives BRAM addr
bram_write_en  output  1  tied 0 (reader never writes)
bram_data_out  input  DATA_WIDTH  BRAM data_out, valid 1 cycle after bram_addr
out_data  output  DATA_WIDTH  stream data
out_valid  output  1  stream valid
out_ready  input  1  stream ready
out_last  output  1  marks the final word of the job

Behaviour:
- Reset values: busy=0, done=0, bram_addr=0, out_valid=0, out_last=0, out_data=0, skid buffer empty, in-flight flag=0, state=IDLE.
- States and transitions:
  - IDLE -> READ on start when num_words>0. Latch the address counter=start_addr and remaining=num_words; busy=1 next cycle.
  - IDLE, start with num_words=0: done pulses the next cycle, no words emitted, busy stays 0.
  - READ: issue reads until remaining reaches 0, then -> DRAIN.
  - DRAIN: wait until the skid buffer is empty and nothing is in flight, then -> IDLE with done=1 for one cycle and busy=0 in that same cycle.
- Issue rule:
  - pop = out_valid & out_ready.
  - A read issues in cycle t iff state=READ, remaining>0, and (count + inflight - pop) < 2, where count is the number of skid entries.
  - An issue drives bram_addr=counter, sets inflight for t+1, increments counter, and decrements remaining.
- Capture: bram_data_out is pushed into the skid buffer in the cycle after an issue (inflight=1) and is ignored otherwise. The BRAM reads every cycle, so data without inflight=1 must never enter the buffer.
- Address arithmetic: the counter wraps modulo 2**ADDR_WIDTH. num_words=2**ADDR_WIDTH reads every location exactly once.
- Stream rules:
  - out_data, out_valid and out_last come from the skid head and are registered; no combinational path from out_ready to out_valid or out_data.
  - Once out_valid=1, out_data and out_last are held stable until pop.
  - out_last=1 only on the word whose issue made remaining 0.
- Latency: start accepted at cycle 0 -> first issue at cycle 1 -> captured at cycle 2 -> out_valid=1 at cycle 3.
- Throughput: with out_ready held high, one word per cycle after the first.
- start while busy is ignored. start and rst in the same cycle: rst wins.
- rst mid-job: the job is abandoned, the buffer is flushed, no done pulse, and out_valid drops the next cycle.
- Output ordering is strictly ascending address (with wrap); no drops or duplicates under any out_ready pattern.

Decomposition:
- Shared package: state encoding (IDLE/READ/DRAIN) and the skid depth constant SKID_DEPTH=2.
- One sub-module, skid_fifo2: a 2-entry synchronous FIFO (DATA_WIDTH+1 bits wide, carrying data plus last) with push, pop, count, head outputs and registered outputs.
- The BRAM itself is instantiated by the parent, not inside this block.

Test Plan:
- BRAM preloaded mem[i]=i+8'h10; start_addr=2, num_words=5, out_ready=1 -> out_data 12,13,14,15,16 on consecutive cycles; first valid at cycle 3 after start; out_last on 16; done one cycle after the last pop.
- Wrap: start_addr=14, num_words=4, depth 16 -> addresses 14,15,0,1 -> data 1E,1F,10,11.
- Backpressure: num_words=6 with out_ready toggling 1,0,0,1,0,1,... randomly -> all 6 words in order, no duplicates; bram_addr never runs more than 2 words ahead of consumption.
- num_words=0 -> out_valid never asserts; done pulses once the cycle after start; busy stays 0.
- Full depth: num_words=16, start_addr=5 -> 16 words covering every address once; out_last on mem[4].
- rst asserted 3 cycles into a 6-word job, then a new start -> no done for the first job; the second job's output is correct and uncontaminated by stale buffer data.
